pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the
//  stall[5:0] vector consumed by PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Sequences exception flushes, deferring them while the data bus is busy.
//  Runs a data-bus timeout watchdog and a saturating stall-cycle counter.
// PARAMETERS
//  TIMEOUT   256  consecutive stallreq_mem cycles before bus_timeout fires (>=2)
//  TO_W      9    watchdog counter width; must hold TIMEOUT
// PORTS
//  clk            in   1   clock, rising edge
//  resetn         in   1   synchronous, active-low reset
//  stallreq_if    in   1   instruction bus not ready
//  stallreq_id    in   1   load-use hazard in ID
//  stallreq_ex    in   1   multi-cycle EX op in progress
//  stallreq_mem   in   1   data bus not ready
//  excp_valid     in   1   exception detected in MEM, single-cycle pulse
//  excp_vector    in   32  handler address for excp_valid
//  stat_clr       in   1   clear stall_cycles
//  stall          out  6   [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = `Stop
//  flush          out  1   clear all pipeline registers; load new_pc into PC
//  new_pc         out  32  flush target, valid while flush=1
//  bus_timeout    out  1   one-cycle pulse, data-bus watchdog expiry
//  stall_cycles   out  32  count of cycles with stall[0]=1, saturating
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=RUN; flush=0; new_pc=0; bus_timeout=0; stall_cycles=0;
//    watchdog=0. stall is 0 while in RUN with no requests.
//  States:
//   RUN: normal operation.
//   FLUSH_WAIT: exception captured; waiting for the data bus to go idle.
//   FLUSH: issues the flush for one cycle.
//  stall is combinational from state and requests, zero latency. Priority:
//   FLUSH         -> 6'b000000
//   FLUSH_WAIT    -> 6'b011111
//   stallreq_mem  -> 6'b011111
//   stallreq_ex   -> 6'b001111 (EX/MEM inserts bubble)
//   stallreq_id   -> 6'b000111
//   stallreq_if   -> 6'b000011
//   otherwise     -> 6'b000000
//  Transitions:
//   RUN & excp_valid & !stallreq_mem -> FLUSH; capture excp_vector into new_pc.
//   RUN & excp_valid & stallreq_mem  -> FLUSH_WAIT; capture excp_vector.
//   FLUSH_WAIT & !stallreq_mem -> FLUSH.
//   FLUSH -> RUN, unconditionally, after 1 cycle.
//  flush is registered: 1 exactly while state==FLUSH. new_pc holds its captured value until the
//    next capture.
//  excp_valid is ignored in FLUSH_WAIT and FLUSH; no queueing.
//  Watchdog counts consecutive cycles with stallreq_mem=1, in any state, and returns to 0 on
//    any cycle with stallreq_mem=0. bus_timeout pulses on the cycle after the count reaches
//    TIMEOUT. The count then holds, so there is one pulse per continuous busy episode. Recovery
//    is software's job; the FSM does not react.
//  stall_cycles increments on each cycle with stall[0]=1 and saturates at 32'hFFFF_FFFF.
//    stat_clr=1 loads 0; clear wins over a simultaneous increment.
//  Reset mid-FLUSH_WAIT or mid-FLUSH aborts the sequence: no flush is issued and the exception
//    is lost.
// STRUCTURE
//  define.v holds `Stop/`NoStop, the 6-bit STALL_* encodings above, and the RUN, FLUSH_WAIT and
//    FLUSH state codes.
//  One natural sub-module: sat_counter (W, sync clear, enable, saturate), used for stall_cycles.
//  Everything else stays inline.
// TESTING
//  1. Reset: hold resetn=0 for 3 cycles with all requests at 1 -> after release, flush=0,
//     stall_cycles=0, new_pc=0.
//  2. Priority: stallreq_id=1 with stallreq_ex=1 -> stall=6'b001111. Add stallreq_mem=1 ->
//     6'b011111. Drop all -> 6'b000000 in the same cycle.
//  3. Clean exception: excp_valid=1, vector 32'h0000_0020, no stalls -> next cycle flush=1,
//     new_pc=32'h20, stall=0. The cycle after that, flush=0.
//  4. Deferred exception: excp_valid while stallreq_mem=1 for 5 cycles -> stall=6'b011111 and
//     flush=0 throughout. flush=1 in the cycle after stallreq_mem drops.
//  5. Watchdog at TIMEOUT=4: stallreq_mem=1 for 10 cycles -> exactly one bus_timeout pulse, on
//     cycle 5. Drop for 1 cycle, reassert for 5 cycles -> a second pulse.
//  6. Counter: preload near 32'hFFFF_FFFE via stall activity -> saturates at 32'hFFFF_FFFF.
//     stat_clr together with stall=1 -> counter reads 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
// Holds the stall-vector encodings, controller state codes, the request
// bundle type and the priority encoder that maps state + requests to stall.
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned STAT_W  = 32;

    // Value of a stall bit that freezes its stage.
    localparam logic STOP = 1'b1;

    // Stall vector encodings: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH      = 2'd2
    } ctrl_state_e;

    // Per-stage stall requests, highest priority first.
    typedef struct packed {
        logic mem;
        logic ex;
        logic id;
        logic ifetch;
    } stall_req_t;

    // Priority encoder: flushing overrides everything, a pending flush holds
    // the pipe as if the data bus were busy, then the deepest request wins.
    function automatic logic [STALL_W-1:0] stall_encode(input ctrl_state_e st,
                                                        input stall_req_t  req);
        logic [STALL_W-1:0] s;
        s = STALL_NONE;
        if (st == FLUSH)           s = STALL_NONE;
        else if (st == FLUSH_WAIT) s = STALL_MEM;
        else if (req.mem)          s = STALL_MEM;
        else if (req.ex)           s = STALL_EX;
        else if (req.id)           s = STALL_ID;
        else if (req.ifetch)       s = STALL_IF;
        return s;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//  clk     in  clock, rising edge
//  resetn  in  synchronous, active-low reset
//  clr     in  load zero; wins over en
//  en      in  increment by one unless already at all-ones
//  count   out registered count value
module pipe_stall_ctrl_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_nxt;

    // Next value: clear first, then increment only below the ceiling.
    always_comb begin
        count_nxt = count_q;
        if (clr) begin
            count_nxt = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_nxt = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clr || en) begin
            count_q <= count_nxt;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller for the 5-stage core.
// Merges per-stage stall requests into the stall vector, sequences exception
// flushes (deferred while the data bus is busy), runs a data-bus timeout
// watchdog and keeps a saturating count of PC-stalled cycles.
// Ports:
//  clk           in   clock, rising edge
//  resetn        in   synchronous, active-low reset
//  stallreq_if   in   instruction bus not ready
//  stallreq_id   in   load-use hazard in ID
//  stallreq_ex   in   multi-cycle EX op in progress
//  stallreq_mem  in   data bus not ready
//  excp_valid    in   exception pulse from MEM
//  excp_vector   in   handler address qualified by excp_valid
//  stat_clr      in   clear stall_cycles
//  stall         out  per-stage freeze vector, combinational
//  flush         out  registered, high for the single FLUSH cycle
//  new_pc        out  registered flush target
//  bus_timeout   out  registered one-cycle watchdog pulse
//  stall_cycles  out  registered saturating count of cycles with stall[0] set
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TO_W    = 9
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               excp_valid,
    input  logic [PC_W-1:0]    excp_vector,
    input  logic               stat_clr,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [PC_W-1:0]    new_pc,
    output logic               bus_timeout,
    output logic [STAT_W-1:0]  stall_cycles
);

    ctrl_state_e     state_q;
    ctrl_state_e     state_nxt;
    logic            flush_q;
    logic            flush_nxt;
    logic [PC_W-1:0] new_pc_q;
    logic [PC_W-1:0] new_pc_nxt;
    logic [TO_W-1:0] wd_q;
    logic [TO_W-1:0] wd_nxt;
    logic            bto_q;
    logic            bto_nxt;
    stall_req_t      req;

    assign req = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id, ifetch: stallreq_if};

    // Zero-latency stall vector.
    assign stall = stall_encode(state_q, req);

    // Flush sequencer: next state, capture of the handler address, flush flag.
    always_comb begin
        state_nxt  = state_q;
        new_pc_nxt = new_pc_q;
        flush_nxt  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (excp_valid) begin
                    new_pc_nxt = excp_vector;
                    state_nxt  = stallreq_mem ? FLUSH_WAIT : FLUSH;
                end
            end
            FLUSH_WAIT: begin
                if (!stallreq_mem) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        // flush is a registered copy of "state is FLUSH".
        flush_nxt = (state_nxt == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= RUN;
            flush_q  <= 1'b0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_nxt;
            flush_q  <= flush_nxt;
            new_pc_q <= new_pc_nxt;
        end
    end

    // Watchdog: counts consecutive busy cycles and parks at TIMEOUT so each
    // busy episode yields one pulse, raised as the count reaches TIMEOUT.
    always_comb begin
        wd_nxt  = wd_q;
        bto_nxt = 1'b0;
        if (!stallreq_mem) begin
            wd_nxt = '0;
        end else if (wd_q != TO_W'(TIMEOUT)) begin
            wd_nxt = wd_q + TO_W'(1);
        end
        bto_nxt = stallreq_mem && (wd_q == TO_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_q  <= '0;
            bto_q <= 1'b0;
        end else begin
            wd_q  <= wd_nxt;
            bto_q <= bto_nxt;
        end
    end

    // Cycles in which the PC is frozen.
    pipe_stall_ctrl_sat_counter #(
        .W (STAT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (stat_clr),
        .en     (stall[0] == STOP),
        .count  (stall_cycles)
    );

    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign bus_timeout = bto_q;

endmodule
